// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM encoding and command bytes.
// Used by both the host transmitter and the keyboard receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_BITS,
    S_ACK,
    S_RELEASE
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_LEDS   = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;

  function automatic logic odd_parity(
    input logic [7:0] d
  );
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_tx_if.sv
// Command-side handshake of the PS/2 host transmitter.
// master issues bytes, slave is the transmitter.
interface ps2_tx_if;

  logic [7:0] data;
  logic       send;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output data,
    output send,
    input  busy,
    input  done,
    input  error
  );

  modport slave (
    input  data,
    input  send,
    output busy,
    output done,
    output error
  );

endinterface

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send,
// 11-bit serial frame clocked by the device, ack and bus release.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       send,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps_clk_i,
  output logic       ps_clk_oe,
  input  logic       ps_dat_i,
  output logic       ps_dat_oe
);

  localparam int CMAX =
    (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
    INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CMAX + 1);

  localparam logic [CW-1:0] INH_LAST =
    CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST =
    CW'(TIMEOUT_CYCLES - 1);

  logic r_clk_m;
  logic r_clk_s;
  logic r_clk_q;
  logic r_dat_m;
  logic r_dat_s;

  ps2_tx_state_e r_state;
  ps2_tx_state_e w_state_n;

  logic [7:0]    r_data;
  logic [7:0]    w_data_n;
  logic          r_par;
  logic          w_par_n;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_n;
  logic [3:0]    r_edge;
  logic [3:0]    w_edge_n;
  logic          r_drv;
  logic          w_drv_n;
  logic          r_done;
  logic          w_done_n;
  logic          r_error;
  logic          w_error_n;

  logic w_fall;
  logic w_tmo;
  logic w_dat_oe;

  assign w_fall = r_clk_q & ~r_clk_s;
  assign w_tmo  = (r_cnt == TMO_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_clk_m <= 1'b1;
      r_clk_s <= 1'b1;
      r_clk_q <= 1'b1;
      r_dat_m <= 1'b1;
      r_dat_s <= 1'b1;
      r_state <= S_IDLE;
      r_data  <= '0;
      r_par   <= 1'b0;
      r_cnt   <= '0;
      r_edge  <= '0;
      r_drv   <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_clk_m <= ps_clk_i;
      r_clk_s <= r_clk_m;
      r_clk_q <= r_clk_s;
      r_dat_m <= ps_dat_i;
      r_dat_s <= r_dat_m;
      r_state <= w_state_n;
      r_data  <= w_data_n;
      r_par   <= w_par_n;
      r_cnt   <= w_cnt_n;
      r_edge  <= w_edge_n;
      r_drv   <= w_drv_n;
      r_done  <= w_done_n;
      r_error <= w_error_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_data_n  = r_data;
    w_par_n   = r_par;
    w_cnt_n   = r_cnt + CW'(1);
    w_edge_n  = r_edge;
    w_drv_n   = r_drv;
    w_done_n  = 1'b0;
    w_error_n = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_cnt_n  = '0;
        w_edge_n = '0;
        w_drv_n  = 1'b0;
        if (send) begin
          w_data_n  = data;
          w_par_n   = odd_parity(data);
          w_state_n = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (r_cnt == INH_LAST) begin
          w_drv_n   = 1'b1;
          w_state_n = S_REQ;
        end
      end
      S_REQ: begin
        if (w_fall) begin
          w_cnt_n   = '0;
          w_edge_n  = 4'd1;
          w_drv_n   = ~r_data[0];
          w_state_n = S_BITS;
        end else if (w_tmo) begin
          w_error_n = 1'b1;
          w_state_n = S_IDLE;
        end
      end
      S_BITS: begin
        if (w_fall) begin
          w_cnt_n  = '0;
          w_edge_n = r_edge + 4'd1;
          if (r_edge == 4'd9) begin
            w_drv_n   = 1'b0;
            w_state_n = S_ACK;
          end else if (r_edge == 4'd8) begin
            w_drv_n = ~r_par;
          end else begin
            w_drv_n = ~r_data[r_edge[2:0]];
          end
        end else if (w_tmo) begin
          w_error_n = 1'b1;
          w_state_n = S_IDLE;
        end
      end
      S_ACK: begin
        if (w_fall) begin
          w_cnt_n = '0;
          if (!r_dat_s) begin
            w_state_n = S_RELEASE;
          end else begin
            w_error_n = 1'b1;
            w_state_n = S_IDLE;
          end
        end else if (w_tmo) begin
          w_error_n = 1'b1;
          w_state_n = S_IDLE;
        end
      end
      S_RELEASE: begin
        if (r_clk_s && r_dat_s) begin
          w_done_n  = 1'b1;
          w_state_n = S_IDLE;
        end else if (w_tmo) begin
          w_error_n = 1'b1;
          w_state_n = S_IDLE;
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase

    // every state entry restarts the shared inhibit/timeout counter
    if (w_state_n != r_state) begin
      w_cnt_n = '0;
    end
  end

  always_comb begin
    w_dat_oe = 1'b0;
    unique case (r_state)
      S_INHIBIT: w_dat_oe = (r_cnt == INH_LAST);
      S_REQ:     w_dat_oe = 1'b1;
      S_BITS:    w_dat_oe = r_drv;
      S_ACK:     w_dat_oe = r_drv;
      default:   w_dat_oe = 1'b0;
    endcase
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign error     = r_error;
  assign ps_clk_oe = (r_state == S_INHIBIT);
  assign ps_dat_oe = w_dat_oe;

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx with an open-drain bus and a
// device model running at a scaled-down PS/2 clock.
`timescale 1ns/1ps
module tb_ps2_tx;
  import ps2_pkg::*;

  localparam int INH  = 20;
  localparam int TMO  = 200;
  localparam int HALF = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;

  ps2_tx_if bus();

  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;
  logic ps_clk_oe;
  logic ps_dat_oe;
  wire  clk_line = ps_clk_oe ? 1'b0 : dev_clk;
  wire  dat_line = ps_dat_oe ? 1'b0 : dev_dat;

  ps2_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock    (clk),
    .reset    (rst),
    .data     (bus.data),
    .send     (bus.send),
    .busy     (bus.busy),
    .done     (bus.done),
    .error    (bus.error),
    .ps_clk_i (clk_line),
    .ps_clk_oe(ps_clk_oe),
    .ps_dat_i (dat_line),
    .ps_dat_oe(ps_dat_oe)
  );

  int n_vec = 0;
  int n_bad = 0;
  int n_done = 0;
  int n_err = 0;
  int n_both = 0;
  int n_busy_bad = 0;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    if (bus.done) n_done++;
    if (bus.error) n_err++;
    if (bus.done && bus.error) n_both++;
    if ((bus.done || bus.error) &&
        (bus.busy || !prev_busy))
      n_busy_bad++;
    prev_busy = bus.busy;
  end

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  task automatic pulse_send(input logic [7:0] d);
    @(negedge clk);
    bus.data = d;
    bus.send = 1'b1;
    @(negedge clk);
    bus.send = 1'b0;
  endtask

  task automatic dev_xfer(
    input  int          n_edges,
    input  bit          ack,
    output logic [10:0] fr,
    output bit          ok
  );
    int t;
    ok = 1'b1;
    fr = '0;
    t = 0;
    while (!ps_clk_oe && t < 50) begin
      @(negedge clk);
      t++;
    end
    t = 0;
    while (ps_clk_oe && t < INH + 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= INH + 50) begin
      check("inhibit_wait", 32'd1, 32'd0);
      ok = 1'b0;
      return;
    end
    for (int k = 0; k < n_edges; k++) begin
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      fr[k] = dat_line;
      if (k == 10) begin
        dev_dat = ack ? 1'b0 : 1'b1;
        repeat (2) @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    dev_clk = 1'b1;
    dev_dat = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (bus.busy && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check(name, 32'd1, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  data;
    bit          ack;
    logic [10:0] frame;
    int          done;
    int          err;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [10:0] fr;
    bit ok;
    int d0;
    int e0;
    int inh;
    int dat_at;
    int n;

    bus.data = '0;
    bus.send = 1'b0;

    tbl[0] = '{8'hED, 1'b1, 11'b1_1_11101101_0, 1, 0};
    tbl[1] = '{8'h00, 1'b1, 11'b1_1_00000000_0, 1, 0};
    tbl[2] = '{8'hFF, 1'b1, 11'b1_1_11111111_0, 1, 0};
    tbl[3] = '{8'h01, 1'b1, 11'b1_0_00000001_0, 1, 0};
    tbl[4] = '{8'hF4, 1'b0, 11'b1_0_11110100_0, 0, 1};
    tbl[5] = '{8'hFA, 1'b1, 11'b1_1_11111010_0, 1, 0};

    // reset values, with send held high during reset
    repeat (3) @(negedge clk);
    bus.send = 1'b1;
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.error, 0);
    check("rst_clk_oe", ps_clk_oe, 0);
    check("rst_dat_oe", ps_dat_oe, 0);
    bus.send = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_send_drop", bus.busy, 0);

    foreach (tbl[i]) begin
      d0 = n_done;
      e0 = n_err;
      pulse_send(tbl[i].data);
      check("busy_rise", bus.busy, 1);
      dev_xfer(11, tbl[i].ack, fr, ok);
      wait_idle("idle_wait");
      check($sformatf("frame_%02h", tbl[i].data),
            fr, tbl[i].frame);
      check("done_cnt", n_done - d0, tbl[i].done);
      check("err_cnt", n_err - e0, tbl[i].err);
      check("busy_end", bus.busy, 0);
      check("oe_end", {ps_clk_oe, ps_dat_oe}, 0);
    end

    // device never clocks: inhibit length, then timeout
    d0 = n_done;
    e0 = n_err;
    pulse_send(PS2_CMD_RESET);
    inh = 0;
    dat_at = 0;
    while (ps_clk_oe && inh < 1000) begin
      inh++;
      if (ps_dat_oe && dat_at == 0) dat_at = inh;
      @(negedge clk);
    end
    check("inhibit_len", inh, INH);
    check("start_bit_at", dat_at, INH);
    n = 0;
    while (!bus.error && n < TMO + 50) begin
      @(negedge clk);
      n++;
    end
    check("timeout_len", n, TMO);
    check("tmo_oe", {ps_clk_oe, ps_dat_oe}, 0);
    check("tmo_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    check("tmo_err_cnt", n_err - e0, 1);
    check("tmo_no_done", n_done - d0, 0);

    // second send mid-transfer is ignored
    d0 = n_done;
    pulse_send(8'h01);
    fork
      dev_xfer(11, 1'b1, fr, ok);
      begin
        repeat (INH + 40) @(negedge clk);
        bus.data = 8'h5A;
        bus.send = 1'b1;
        @(negedge clk);
        bus.send = 1'b0;
      end
    join
    wait_idle("busy_send_wait");
    check("busy_send_frame", fr, 11'b1_0_00000001_0);
    check("busy_send_done", n_done - d0, 1);
    repeat (4) @(negedge clk);
    check("busy_send_noq", bus.busy, 0);

    // reset after edge 5, then a clean transfer
    pulse_send(PS2_CMD_LEDS);
    dev_xfer(5, 1'b1, fr, ok);
    check("part_frame", fr[4:0], 5'b11010);
    check("part_busy", bus.busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_oe", {ps_clk_oe, ps_dat_oe}, 0);
    check("mid_rst_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    d0 = n_done;
    e0 = n_err;
    pulse_send(PS2_CMD_ENABLE);
    dev_xfer(11, 1'b1, fr, ok);
    wait_idle("post_rst_wait");
    check("post_rst_frame", fr, 11'b1_0_11110100_0);
    check("post_rst_done", n_done - d0, 1);
    check("post_rst_err", n_err - e0, 0);

    check("done_err_overlap", n_both, 0);
    check("busy_fall_align", n_busy_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
